// File: rtl/mux_n_arb.sv
// mux_n_arb: N-channel registered mux with valid/ready handshakes and explicit-select or round-robin arbitration.
module mux_n_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d, gnt_data;
  logic [SEL_W-1:0] out_chan_q, out_chan_d, rr_last_q, rr_last_d, gnt;
  logic             out_valid_q, out_valid_d, load_en, gnt_vld, xfer;
  int               idx;
  always_comb begin
    load_en = !out_valid_q || out_ready;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (mode) begin
      // Scan from farthest to nearest so the nearest valid channel after rr_last wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = (int'(rr_last_q) + k) % CHANNELS;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (select == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(i);
        end
      end
    end
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
    xfer        = rst_n && load_en && gnt_vld;
    in_ready    = xfer ? CHANNELS'(1) << gnt : '0;
    out_data_d  = xfer ? gnt_data : out_data_q;
    out_chan_d  = xfer ? gnt : out_chan_q;
    out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    rr_last_d   = (xfer && mode) ? gnt : rr_last_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_last_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_last_q   <= rr_last_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_n_arb.sv
// tb_mux_n_arb: directed scenario tasks with hand-computed expectations for mux_n_arb.
module tb_mux_n_arb;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_ready;
  logic [1:0]   select, out_chan;
  logic         mode, out_valid, out_ready;
  logic [31:0]  out_data;
  int           checks = 0;
  int           errors = 0;

  mux_n_arb #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .select(select), .mode(mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b1; select = 2'd0;
    in_data = {32'h33, 32'h22, 32'h11, 32'h44};
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%h chan=%0d, want 0/0/0", out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
  endtask

  task automatic test_select();
    do_reset();
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {32'd3, 32'd2, 32'd1, 32'd0};
    select = 2'd1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd1 || out_chan !== 2'd1) begin
      errors++; $display("FAIL sel1: valid=%b data=%h chan=%0d, want 1/1/1", out_valid, out_data, out_chan);
    end
    select = 2'd0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd0 || out_chan !== 2'd0) begin
      errors++; $display("FAIL sel0: valid=%b data=%h chan=%0d, want 1/0/0", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_first_ready: got %b want 0001", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== 32'hA0 + 32'(i % 4)) begin
        errors++; $display("FAIL rr_seq[%0d]: valid=%b chan=%0d data=%h, want 1/%0d/%h", i, out_valid, out_chan, out_data, i % 4, 32'hA0 + 32'(i % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; out_ready = 1'b0; in_valid = 4'b0100;
    in_data = {32'h0, 32'h55, 32'h0, 32'h0};
    tick();
    in_data[64 +: 32] = 32'h66;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h55 || out_chan !== 2'd2 || in_ready !== 4'b0000) begin
        errors++; $display("FAIL stall[%0d]: valid=%b data=%h chan=%0d rdy=%b, want 1/55/2/0000", i, out_valid, out_data, out_chan, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL release_ready: got %b want 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h66) begin
      errors++; $display("FAIL no_bubble: valid=%b data=%h, want 1/66", out_valid, out_data);
    end
    in_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h66 || out_chan !== 2'd2) begin
      errors++; $display("FAIL drain: valid=%b data=%h chan=%0d, want 0/66/2", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_select_invalid();
    do_reset();
    mode = 1'b0; select = 2'd3; out_ready = 1'b1; in_valid = 4'b0111;
    in_data = {32'hDEADBEEF, 32'h2, 32'h1, 32'h0};
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL sel3_idle_ready: got %b want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sel3_idle_valid: got %b want 0", out_valid);
    end
    in_valid = 4'b1111;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_chan !== 2'd3) begin
      errors++; $display("FAIL sel3_load: valid=%b data=%h chan=%0d, want 1/deadbeef/3", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0001;
    in_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_chan !== exp_seq[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL fair[%0d]: chan=%0d valid=%b, want %0d/1", i, out_chan, out_valid, exp_seq[i]);
      end
    end
    mode = 1'b0; select = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_chan !== 2'd0 || out_data !== 32'hC0) begin
        errors++; $display("FAIL mode0_hold[%0d]: chan=%0d data=%h, want 0/c0", i, out_chan, out_data);
      end
    end
    mode = 1'b1;
    tick();
    checks++;
    if (out_chan !== 2'd3) begin
      errors++; $display("FAIL rr_unchanged: chan=%0d want 3", out_chan);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 1'b1; out_ready = 1'b0; in_valid = 4'b0100;
    in_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    tick();
    tick();
    rst_n = 1'b0;
    in_valid = 4'b1111;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
      errors++; $display("FAIL midreset: valid=%b data=%h chan=%0d, want 0/0/0", out_valid, out_data, out_chan);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'hE0) begin
      errors++; $display("FAIL post_reset_grant: valid=%b chan=%0d data=%h, want 1/0/e0", out_valid, out_chan, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_select_invalid();
    test_fairness();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
